// File: rtl/multiciclo_control_if.sv
// rtl/multiciclo_control_if.sv - handshake/control bundle between the multicycle sequencer and its datapath
interface multiciclo_control_if;
  logic [6:0] Opcode_i;
  logic       Zero_i;
  logic       Memready_i;
  logic       Pcwrite_o;
  logic       Pcsel_o;
  logic       Irwrite_o;
  logic       Iord_o;
  logic       Memread_o;
  logic       Memwrite_o;
  logic       Memtoreg_o;
  logic       Regwrite_o;
  logic       Alusrc_o;
  logic [1:0] Aluop_o;
  logic       Branch_o;
  logic       Instret_o;
  logic [1:0] Fault_o;
  logic [2:0] State_o;

  modport master (
    input  Opcode_i, Zero_i, Memready_i,
    output Pcwrite_o, Pcsel_o, Irwrite_o, Iord_o, Memread_o, Memwrite_o,
           Memtoreg_o, Regwrite_o, Alusrc_o, Aluop_o, Branch_o, Instret_o,
           Fault_o, State_o
  );

  modport slave (
    output Opcode_i, Zero_i, Memready_i,
    input  Pcwrite_o, Pcsel_o, Irwrite_o, Iord_o, Memread_o, Memwrite_o,
           Memtoreg_o, Regwrite_o, Alusrc_o, Aluop_o, Branch_o, Instret_o,
           Fault_o, State_o
  );
endinterface

// File: rtl/multiciclo_control.sv
// rtl/multiciclo_control.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout and trap
module multiciclo_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input logic                  clk_i,
  input logic                  rst_i,
  multiciclo_control_if.master bus
);
  localparam int CW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NOP, C_B, C_ST, C_LD, C_I, C_R, C_FENCE, C_SYS
  } op_class_t;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;

  state_t        state;
  op_class_t     op_class;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    fault;

  function automatic op_class_t classify(input logic [6:0] opcode);
    case (opcode)
      7'b1100011: classify = C_B;
      7'b0100011: classify = C_ST;
      7'b0000011: classify = C_LD;
      7'b0010011: classify = C_I;
      7'b0110011: classify = C_R;
      7'b0001111: classify = C_FENCE;
      7'b1110011: classify = C_SYS;
      default:    classify = C_NOP;
    endcase
  endfunction

  // The timeout fires on the wait cycle that would bring the count to MEM_TIMEOUT.
  logic timeout_hit;
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_FETCH;
      op_class <= C_NOP;
      wait_cnt <= '0;
      fault    <= F_NONE;
    end else begin
      case (state)
        S_FETCH, S_MEM: begin
          if (bus.Memready_i) begin
            wait_cnt <= '0;
            if (state == S_FETCH)     state <= S_DECODE;
            else if (op_class == C_LD) state <= S_WB;
            else                       state <= S_FETCH;
          end else if (timeout_hit) begin
            wait_cnt <= '0;
            state    <= S_TRAP;
            fault    <= F_TIMEOUT;
          end else if (MEM_TIMEOUT != 0) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          op_class <= classify(bus.Opcode_i);
          if (classify(bus.Opcode_i) == C_NOP) begin
            state <= S_TRAP;
            fault <= F_ILLEGAL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          case (op_class)
            C_LD, C_ST: state <= S_MEM;
            C_R, C_I:   state <= S_WB;
            default:    state <= S_FETCH;
          endcase
        end
        S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        S_TRAP: begin
          wait_cnt <= '0;
        end
        default: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
      endcase
    end
  end

  logic       pcwrite, pcsel, irwrite, iord, memread, memwrite;
  logic       memtoreg, regwrite, alusrc, branch, instret;
  logic [1:0] aluop;

  always_comb begin
    pcwrite  = 1'b0;
    pcsel    = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrc   = 1'b0;
    branch   = 1'b0;
    instret  = 1'b0;
    aluop    = 2'b00;
    case (state)
      S_FETCH: begin
        memread = 1'b1;
        if (bus.Memready_i) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
        end
      end
      S_EXEC: begin
        case (op_class)
          C_B: begin
            aluop   = 2'b01;
            branch  = 1'b1;
            pcwrite = bus.Zero_i;
            pcsel   = 1'b1;
            instret = 1'b1;
          end
          C_LD, C_ST: alusrc = 1'b1;
          C_I: begin
            aluop  = 2'b11;
            alusrc = 1'b1;
          end
          C_R: aluop = 2'b10;
          C_FENCE, C_SYS: begin
            aluop   = 2'b11;
            instret = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        iord     = 1'b1;
        alusrc   = 1'b1;
        memread  = (op_class == C_LD);
        memwrite = (op_class == C_ST);
        instret  = (op_class == C_ST) && bus.Memready_i;
      end
      S_WB: begin
        regwrite = 1'b1;
        instret  = 1'b1;
        memtoreg = (op_class == C_LD);
        case (op_class)
          C_LD:    alusrc = 1'b1;
          C_I: begin
            aluop  = 2'b11;
            alusrc = 1'b1;
          end
          C_R:     aluop = 2'b10;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.Pcwrite_o  = pcwrite;
  assign bus.Pcsel_o    = pcsel;
  assign bus.Irwrite_o  = irwrite;
  assign bus.Iord_o     = iord;
  assign bus.Memread_o  = memread;
  assign bus.Memwrite_o = memwrite;
  assign bus.Memtoreg_o = memtoreg;
  assign bus.Regwrite_o = regwrite;
  assign bus.Alusrc_o   = alusrc;
  assign bus.Aluop_o    = aluop;
  assign bus.Branch_o   = branch;
  assign bus.Instret_o  = instret;
  assign bus.Fault_o    = fault;
  assign bus.State_o    = state;
endmodule

// File: tb/tb_multiciclo_control.sv
// tb/tb_multiciclo_control.sv - directed self-checking bench for multiciclo_control
module tb_multiciclo_control;
  logic clk;
  logic rst;
  int   tests;
  int   failed;

  multiciclo_control_if bus();

  multiciclo_control #(.MEM_TIMEOUT(15)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock, then let combinational outputs settle before driving/checking.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic ready, input logic zero);
    bus.Opcode_i   = op;
    bus.Memready_i = ready;
    bus.Zero_i     = zero;
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    drive(7'h00, 1'b0, 1'b0);
    cyc();
    chk("rst_state",    8'(bus.State_o),    8'd0);
    chk("rst_memread",  8'(bus.Memread_o),  8'd1);
    chk("rst_memwrite", 8'(bus.Memwrite_o), 8'd0);
    chk("rst_regwrite", 8'(bus.Regwrite_o), 8'd0);
    chk("rst_irwrite",  8'(bus.Irwrite_o),  8'd0);
    chk("rst_aluop",    8'(bus.Aluop_o),    8'd0);
    chk("rst_fault",    8'(bus.Fault_o),    8'd0);
    chk("rst_instret",  8'(bus.Instret_o),  8'd0);
    rst = 1'b0;

    // R-type, zero wait: FETCH, DECODE, EXEC, WB, FETCH
    drive(7'b0110011, 1'b1, 1'b0);
    chk("r_fetch_state",   8'(bus.State_o),   8'd0);
    chk("r_fetch_irwrite", 8'(bus.Irwrite_o), 8'd1);
    chk("r_fetch_pcwrite", 8'(bus.Pcwrite_o), 8'd1);
    chk("r_fetch_pcsel",   8'(bus.Pcsel_o),   8'd0);
    cyc();
    chk("r_decode_state",  8'(bus.State_o),    8'd1);
    chk("r_decode_rw",     8'(bus.Regwrite_o), 8'd0);
    cyc();
    chk("r_exec_state",    8'(bus.State_o),    8'd2);
    chk("r_exec_aluop",    8'(bus.Aluop_o),    8'd2);
    chk("r_exec_alusrc",   8'(bus.Alusrc_o),   8'd0);
    chk("r_exec_rw",       8'(bus.Regwrite_o), 8'd0);
    chk("r_exec_instret",  8'(bus.Instret_o),  8'd0);
    cyc();
    chk("r_wb_state",      8'(bus.State_o),    8'd4);
    chk("r_wb_aluop",      8'(bus.Aluop_o),    8'd2);
    chk("r_wb_rw",         8'(bus.Regwrite_o), 8'd1);
    chk("r_wb_memtoreg",   8'(bus.Memtoreg_o), 8'd0);
    chk("r_wb_instret",    8'(bus.Instret_o),  8'd1);
    cyc();
    chk("r_back_fetch",    8'(bus.State_o),    8'd0);

    // Load with three MEM wait cycles
    drive(7'b0000011, 1'b1, 1'b0);
    cyc();
    chk("ld_decode",       8'(bus.State_o),  8'd1);
    cyc();
    chk("ld_exec_state",   8'(bus.State_o),  8'd2);
    chk("ld_exec_aluop",   8'(bus.Aluop_o),  8'd0);
    chk("ld_exec_alusrc",  8'(bus.Alusrc_o), 8'd1);
    drive(7'b0000011, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) drive(7'b0000011, 1'b1, 1'b0);
      chk("ld_mem_state",    8'(bus.State_o),    8'd3);
      chk("ld_mem_memread",  8'(bus.Memread_o),  8'd1);
      chk("ld_mem_memwrite", 8'(bus.Memwrite_o), 8'd0);
      chk("ld_mem_iord",     8'(bus.Iord_o),     8'd1);
      chk("ld_mem_instret",  8'(bus.Instret_o),  8'd0);
    end
    cyc();
    chk("ld_wb_state",     8'(bus.State_o),    8'd4);
    chk("ld_wb_memtoreg",  8'(bus.Memtoreg_o), 8'd1);
    chk("ld_wb_rw",        8'(bus.Regwrite_o), 8'd1);
    chk("ld_wb_instret",   8'(bus.Instret_o),  8'd1);
    cyc();
    chk("ld_back_fetch",   8'(bus.State_o),    8'd0);

    // Branch taken then not taken
    for (int z = 1; z >= 0; z--) begin
      drive(7'b1100011, 1'b1, z[0]);
      cyc();
      cyc();
      chk("b_exec_state",   8'(bus.State_o),   8'd2);
      chk("b_exec_branch",  8'(bus.Branch_o),  8'd1);
      chk("b_exec_pcwrite", 8'(bus.Pcwrite_o), 8'(z[0]));
      chk("b_exec_pcsel",   8'(bus.Pcsel_o),   8'd1);
      chk("b_exec_aluop",   8'(bus.Aluop_o),   8'd1);
      chk("b_exec_instret", 8'(bus.Instret_o), 8'd1);
      cyc();
      chk("b_next_fetch",   8'(bus.State_o),   8'd0);
    end

    // Illegal opcode traps and stays quiet until reset
    drive(7'b1111111, 1'b1, 1'b0);
    cyc();
    cyc();
    chk("ill_state", 8'(bus.State_o), 8'd5);
    chk("ill_fault", 8'(bus.Fault_o), 8'd1);
    for (int i = 0; i < 4; i++) begin
      drive(7'b0110011, i[0], 1'b1);
      chk("ill_memread",  8'(bus.Memread_o),  8'd0);
      chk("ill_regwrite", 8'(bus.Regwrite_o), 8'd0);
      cyc();
      chk("ill_hold",     8'(bus.State_o),    8'd5);
      chk("ill_fault_h",  8'(bus.Fault_o),    8'd1);
    end
    rst = 1'b1;
    #1;
    chk("ill_rst_fault", 8'(bus.Fault_o), 8'd0);
    chk("ill_rst_state", 8'(bus.State_o), 8'd0);
    rst = 1'b0;

    // FETCH timeout after 15 low cycles
    drive(7'b0110011, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cyc();
    chk("to_still_fetch", 8'(bus.State_o), 8'd0);
    chk("to_no_fault",    8'(bus.Fault_o), 8'd0);
    cyc();
    chk("to_trap",        8'(bus.State_o), 8'd5);
    chk("to_fault",       8'(bus.Fault_o), 8'd2);
    rst = 1'b1;
    #1;
    rst = 1'b0;

    // Ack on the 15th wait cycle wins over the timeout
    drive(7'b0100011, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) cyc();
    drive(7'b0100011, 1'b1, 1'b0);
    cyc();
    chk("ack15_decode", 8'(bus.State_o), 8'd1);
    chk("ack15_fault",  8'(bus.Fault_o), 8'd0);

    // Store, then asynchronous reset in MEM
    cyc();
    chk("st_exec", 8'(bus.State_o), 8'd2);
    drive(7'b0100011, 1'b0, 1'b0);
    cyc();
    chk("st_mem_state",    8'(bus.State_o),    8'd3);
    chk("st_mem_memwrite", 8'(bus.Memwrite_o), 8'd1);
    chk("st_mem_memread",  8'(bus.Memread_o),  8'd0);
    chk("st_mem_iord",     8'(bus.Iord_o),     8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("st_rst_memwrite", 8'(bus.Memwrite_o), 8'd0);
    chk("st_rst_state",    8'(bus.State_o),    8'd0);
    rst = 1'b0;
    cyc();
    chk("st_after_state",   8'(bus.State_o),   8'd0);
    chk("st_after_memread", 8'(bus.Memread_o), 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
